// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline stall/flush sequencer.
//   - Stage register indices (PC=0 ... MEM2_WB=6)
//   - Sequencer state enum (RUN / FWAIT)
//   - Stall-source priority encoding
//   - Mask helpers that turn a stall stage into hold / bubble vectors
package pipe_ctrl_pkg;

    localparam int NUM_STAGES    = 7;
    localparam int STG_PC        = 0;
    localparam int STG_PF_IF     = 1;
    localparam int STG_IF_ID     = 2;
    localparam int STG_ID_EX     = 3;
    localparam int STG_EX_MEM1   = 4;
    localparam int STG_MEM1_MEM2 = 5;
    localparam int STG_MEM2_WB   = 6;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FWAIT = 1'b1
    } state_e;

    // Listed from lowest to highest priority.
    typedef enum logic [2:0] {
        SRC_NONE     = 3'd0,
        SRC_ICACHE   = 3'd1,
        SRC_LOAD_USE = 3'd2,
        SRC_DIV      = 3'd3,
        SRC_EXC      = 3'd4,
        SRC_DCACHE   = 3'd5
    } stall_src_e;

    // Registers PC..R_k are held by a stall at stage k.
    function automatic logic [NUM_STAGES-1:0] hold_mask(input int k);
        for (int i = 0; i < NUM_STAGES; i++) begin
            hold_mask[i] = (i <= k);
        end
    endfunction

    // The register just younger than the stall point receives a bubble.
    // Flush bits exist only for PF_IF..MEM2_WB (the PC is never flushed).
    function automatic logic [NUM_STAGES-1:1] bubble_mask(input int k);
        for (int i = 1; i < NUM_STAGES; i++) begin
            bubble_mask[i] = (i == k + 1);
        end
    endfunction

endpackage

// File: rtl/pipe_ctrl_div_stall_cnt.sv
// div_stall_cnt: divider occupancy counter.
// Holds EX for exactly DIV_CYCLES cycles per divide, then lets the divide
// leave EX once before another divide may start counting.
//   clk       in   clock
//   rst       in   asynchronous active-low reset
//   EX_start  in   divide instruction present in EX
//   advance   in   EX_MEM1 write-enable (the divide leaves EX)
//   clear     in   accepted exception flush; abandons the divide
//   div_busy  out  divider is stalling EX
module div_stall_cnt #(
    parameter int DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic EX_start,
    input  logic advance,
    input  logic clear,
    output logic div_busy
);

    localparam int                 CNT_W    = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DIV_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_div_done;

    assign div_busy = EX_start & ~r_div_done;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_div_done <= 1'b0;
        end else if (clear) begin
            r_cnt      <= '0;
            r_div_done <= 1'b0;
        end else if (div_busy) begin
            // Counting continues even when a younger-stage stall masks
            // div_busy at the pipeline, so the latency stays fixed.
            if (r_cnt == CNT_LAST) begin
                r_cnt      <= '0;
                r_div_done <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (advance) begin
            r_div_done <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the seven-register MIPS pipeline
// (PC, PF_IF, IF_ID, ID_EX, EX_MEM1, MEM1_MEM2, MEM2_WB).
//   Inputs : clk, rst (async active-low), icache_stall, icache_busy,
//            load_use, EX_start, dcache_stall, exc_flush
//   Outputs: <reg>Wr write-enables, <stage>_Flush bubble inserts,
//            fetch_cancel (drop returning icache data), div_busy
// Optional: PIPE_CTRL_PERF_EN adds perf_stall_cyc and perf_flush_cnt.
// All enables are combinational from inputs plus registered state.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_stall,
    input  logic        icache_busy,
    input  logic        load_use,
    input  logic        EX_start,
    input  logic        dcache_stall,
    input  logic        exc_flush,
    output logic        PCWr,
    output logic        PF_IFWr,
    output logic        IF_IDWr,
    output logic        ID_EXWr,
    output logic        EX_MEM1Wr,
    output logic        MEM1_MEM2Wr,
    output logic        MEM2_WBWr,
    output logic        PF_Flush,
    output logic        IF_Flush,
    output logic        ID_Flush,
    output logic        EX_Flush,
    output logic        MEM1_Flush,
    output logic        MEM2_Flush,
    output logic        fetch_cancel,
    output logic        div_busy
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_flush_cnt
`endif
);

    state_e                  r_state;
    stall_src_e              w_src;
    logic                    w_div_busy;
    logic                    w_exc_accept;
    logic [NUM_STAGES-1:0]   w_wr;
    logic [NUM_STAGES-1:1]   w_flush;

    // A flush raised during FWAIT finds the front already empty: ignore it.
    assign w_exc_accept = (r_state == ST_RUN) & exc_flush & ~dcache_stall;

    div_stall_cnt #(.DIV_CYCLES(DIV_CYCLES)) u_div_cnt (
        .clk      (clk),
        .rst      (rst),
        .EX_start (EX_start),
        .advance  (w_wr[STG_EX_MEM1]),
        .clear    (w_exc_accept),
        .div_busy (w_div_busy)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        w_src = SRC_NONE;
        if (dcache_stall)      w_src = SRC_DCACHE;
        else if (w_exc_accept) w_src = SRC_EXC;
        else if (w_div_busy)   w_src = SRC_DIV;
        else if (load_use)     w_src = SRC_LOAD_USE;
        else if (icache_stall) w_src = SRC_ICACHE;
    end

    always_comb begin
        w_wr    = '1;
        w_flush = '0;
        unique case (w_src)
            SRC_DCACHE: begin
                w_wr    = ~hold_mask(STG_MEM1_MEM2);
                w_flush = bubble_mask(STG_MEM1_MEM2);
            end
            SRC_EXC: begin
                // PC loads the vector/EPC; everything up to MEM1_MEM2 is
                // squashed while the instruction in MEM2 still retires.
                w_flush[STG_MEM1_MEM2:STG_PF_IF] = '1;
            end
            SRC_DIV: begin
                w_wr    = ~hold_mask(STG_ID_EX);
                w_flush = bubble_mask(STG_ID_EX);
            end
            SRC_LOAD_USE: begin
                w_wr    = ~hold_mask(STG_IF_ID);
                w_flush = bubble_mask(STG_IF_ID);
            end
            SRC_ICACHE: begin
                w_wr    = ~hold_mask(STG_PF_IF);
                w_flush = bubble_mask(STG_PF_IF);
            end
            default: ;
        endcase
        // While the cancelled refill drains, the front end stays frozen and
        // keeps feeding bubbles; older registers follow the normal rules.
        if (r_state == ST_FWAIT) begin
            w_wr[STG_PC]       = 1'b0;
            w_wr[STG_PF_IF]    = 1'b0;
            w_flush[STG_IF_ID] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            unique case (r_state)
                ST_RUN:   if (w_exc_accept && icache_busy) r_state <= ST_FWAIT;
                ST_FWAIT: if (!icache_busy)                r_state <= ST_RUN;
                default:                                   r_state <= ST_RUN;
            endcase
        end
    end

    assign PCWr         = w_wr[STG_PC];
    assign PF_IFWr      = w_wr[STG_PF_IF];
    assign IF_IDWr      = w_wr[STG_IF_ID];
    assign ID_EXWr      = w_wr[STG_ID_EX];
    assign EX_MEM1Wr    = w_wr[STG_EX_MEM1];
    assign MEM1_MEM2Wr  = w_wr[STG_MEM1_MEM2];
    assign MEM2_WBWr    = w_wr[STG_MEM2_WB];
    assign PF_Flush     = w_flush[STG_PF_IF];
    assign IF_Flush     = w_flush[STG_IF_ID];
    assign ID_Flush     = w_flush[STG_ID_EX];
    assign EX_Flush     = w_flush[STG_EX_MEM1];
    assign MEM1_Flush   = w_flush[STG_MEM1_MEM2];
    assign MEM2_Flush   = w_flush[STG_MEM2_WB];
    assign fetch_cancel = (r_state == ST_FWAIT);
    assign div_busy     = w_div_busy;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_perf_stall_cyc;
    logic [31:0] r_perf_flush_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_stall_cyc <= '0;
            r_perf_flush_cnt <= '0;
        end else begin
            if (!(&w_wr)) r_perf_stall_cyc <= r_perf_stall_cyc + 32'd1;
            if (w_exc_accept) r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
        end
    end

    assign perf_stall_cyc = r_perf_stall_cyc;
    assign perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl (DIV_CYCLES=32).
// Outputs are packed as {7 Wr (PC..MEM2_WB), 6 Flush (PF..MEM2),
// fetch_cancel, div_busy} and compared against hand-written patterns.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic icache_stall, icache_busy, load_use, EX_start, dcache_stall, exc_flush;
    logic PCWr, PF_IFWr, IF_IDWr, ID_EXWr, EX_MEM1Wr, MEM1_MEM2Wr, MEM2_WBWr;
    logic PF_Flush, IF_Flush, ID_Flush, EX_Flush, MEM1_Flush, MEM2_Flush;
    logic fetch_cancel, div_busy;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cyc, perf_flush_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [14:0] EXP_IDLE   = 15'b1111111_000000_0_0;
    localparam logic [14:0] EXP_ICACHE = 15'b0011111_010000_0_0;
    localparam logic [14:0] EXP_LU     = 15'b0001111_001000_0_0;
    localparam logic [14:0] EXP_DIV    = 15'b0000111_000100_0_1;
    localparam logic [14:0] EXP_DC     = 15'b0000001_000001_0_0;
    localparam logic [14:0] EXP_DC_DB  = 15'b0000001_000001_0_1;
    localparam logic [14:0] EXP_EXC    = 15'b1111111_111110_0_0;
    localparam logic [14:0] EXP_EXC_DB = 15'b1111111_111110_0_1;
    localparam logic [14:0] EXP_FW     = 15'b0011111_010000_1_0;

    logic [14:0] obs;
    assign obs = {PCWr, PF_IFWr, IF_IDWr, ID_EXWr, EX_MEM1Wr, MEM1_MEM2Wr, MEM2_WBWr,
                  PF_Flush, IF_Flush, ID_Flush, EX_Flush, MEM1_Flush, MEM2_Flush,
                  fetch_cancel, div_busy};

    pipe_ctrl #(.DIV_CYCLES(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .icache_stall (icache_stall),
        .icache_busy  (icache_busy),
        .load_use     (load_use),
        .EX_start     (EX_start),
        .dcache_stall (dcache_stall),
        .exc_flush    (exc_flush),
        .PCWr         (PCWr),
        .PF_IFWr      (PF_IFWr),
        .IF_IDWr      (IF_IDWr),
        .ID_EXWr      (ID_EXWr),
        .EX_MEM1Wr    (EX_MEM1Wr),
        .MEM1_MEM2Wr  (MEM1_MEM2Wr),
        .MEM2_WBWr    (MEM2_WBWr),
        .PF_Flush     (PF_Flush),
        .IF_Flush     (IF_Flush),
        .ID_Flush     (ID_Flush),
        .EX_Flush     (EX_Flush),
        .MEM1_Flush   (MEM1_Flush),
        .MEM2_Flush   (MEM2_Flush),
        .fetch_cancel (fetch_cancel),
        .div_busy     (div_busy)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cyc (perf_stall_cyc),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        icache_stall = 1'b0;
        icache_busy  = 1'b0;
        load_use     = 1'b0;
        EX_start     = 1'b0;
        dcache_stall = 1'b0;
        exc_flush    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_idle();
        @(negedge clk);
        n_checks++;
        if (obs !== EXP_IDLE) begin
            n_errors++;
            $display("FAIL reset_held: got %b want %b", obs, EXP_IDLE);
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs !== EXP_IDLE) begin
            n_errors++;
            $display("FAIL reset_released: got %b want %b", obs, EXP_IDLE);
        end
        tick();
    endtask

    task automatic test_icache_stall();
        for (int i = 0; i < 3; i++) begin
            icache_stall = 1'b1;
            @(negedge clk);
            n_checks++;
            if (obs !== EXP_ICACHE) begin
                n_errors++;
                $display("FAIL icache_stall cyc%0d: got %b want %b", i, obs, EXP_ICACHE);
            end
            tick();
        end
        drive_idle();
        @(negedge clk);
        n_checks++;
        if (obs !== EXP_IDLE) begin
            n_errors++;
            $display("FAIL icache_release: got %b want %b", obs, EXP_IDLE);
        end
        tick();
    endtask

    task automatic test_load_use();
        load_use     = 1'b1;
        icache_stall = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs !== EXP_LU) begin
            n_errors++;
            $display("FAIL load_use_with_icache: got %b want %b", obs, EXP_LU);
        end
        tick();
        icache_stall = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs !== EXP_LU) begin
            n_errors++;
            $display("FAIL load_use_alone: got %b want %b", obs, EXP_LU);
        end
        tick();
        drive_idle();
    endtask

    // Holds EX_start for n cycles and expects the divide stall each cycle.
    task automatic run_div(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            EX_start = 1'b1;
            @(negedge clk);
            n_checks++;
            if (obs !== EXP_DIV) begin
                n_errors++;
                $display("FAIL %s cyc%0d: got %b want %b", tag, i, obs, EXP_DIV);
            end
            tick();
        end
    endtask

    // EX_start still high, divide done: EX must advance with no stall.
    task automatic expect_div_release(input string tag);
        EX_start = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs !== EXP_IDLE) begin
            n_errors++;
            $display("FAIL %s: got %b want %b", tag, obs, EXP_IDLE);
        end
        tick();
        EX_start = 1'b0;
    endtask

    task automatic test_div();
        run_div(32, "div_full");
        expect_div_release("div_release");
        // Divide overlapped by a dcache stall still counts the hidden cycles.
        for (int i = 0; i < 5; i++) begin
            EX_start     = 1'b1;
            dcache_stall = 1'b1;
            @(negedge clk);
            n_checks++;
            if (obs !== EXP_DC_DB) begin
                n_errors++;
                $display("FAIL div_masked cyc%0d: got %b want %b", i, obs, EXP_DC_DB);
            end
            tick();
        end
        dcache_stall = 1'b0;
        run_div(27, "div_after_mask");
        expect_div_release("div_masked_release");
    endtask

    task automatic test_exc_over_div();
        run_div(5, "div_pre_exc");
        EX_start  = 1'b1;
        exc_flush = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs !== EXP_EXC_DB) begin
            n_errors++;
            $display("FAIL exc_over_div: got %b want %b", obs, EXP_EXC_DB);
        end
        tick();
        exc_flush = 1'b0;
        // Counter was cleared by the flush: a fresh full-length stall follows.
        run_div(32, "div_after_exc");
        expect_div_release("div_after_exc_release");
    endtask

    task automatic test_fetch_cancel();
        exc_flush   = 1'b1;
        icache_busy = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs !== EXP_EXC) begin
            n_errors++;
            $display("FAIL fwait_accept: got %b want %b", obs, EXP_EXC);
        end
        tick();
        // exc_flush stays high on the first FWAIT cycle and must be ignored.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== EXP_FW) begin
                n_errors++;
                $display("FAIL fwait_busy cyc%0d: got %b want %b", i, obs, EXP_FW);
            end
            tick();
            exc_flush = 1'b0;
        end
        icache_busy = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs !== EXP_FW) begin
            n_errors++;
            $display("FAIL fwait_exit: got %b want %b", obs, EXP_FW);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (obs !== EXP_IDLE) begin
            n_errors++;
            $display("FAIL fwait_back_to_run: got %b want %b", obs, EXP_IDLE);
        end
        tick();
    endtask

    task automatic test_dcache_exc();
        for (int i = 0; i < 2; i++) begin
            dcache_stall = 1'b1;
            exc_flush    = 1'b1;
            @(negedge clk);
            n_checks++;
            if (obs !== EXP_DC) begin
                n_errors++;
                $display("FAIL dcache_over_exc cyc%0d: got %b want %b", i, obs, EXP_DC);
            end
            tick();
        end
        dcache_stall = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs !== EXP_EXC) begin
            n_errors++;
            $display("FAIL exc_after_dcache: got %b want %b", obs, EXP_EXC);
        end
        tick();
        exc_flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs !== EXP_IDLE) begin
            n_errors++;
            $display("FAIL exc_single_cycle: got %b want %b", obs, EXP_IDLE);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        run_div(10, "div_pre_reset");
        EX_start = 1'b0;
        rst      = 1'b0;
        #1;
        n_checks++;
        if (obs !== EXP_IDLE) begin
            n_errors++;
            $display("FAIL reset_mid_div_async: got %b want %b", obs, EXP_IDLE);
        end
        #1;
        rst = 1'b1;
        tick();
        run_div(32, "div_after_reset");
        expect_div_release("div_after_reset_release");
        // Reset out of FWAIT: no fetch_cancel and no pending flush afterwards.
        exc_flush   = 1'b1;
        icache_busy = 1'b1;
        tick();
        exc_flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs !== EXP_FW) begin
            n_errors++;
            $display("FAIL fwait_pre_reset: got %b want %b", obs, EXP_FW);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (obs !== EXP_IDLE) begin
            n_errors++;
            $display("FAIL reset_in_fwait: got %b want %b", obs, EXP_IDLE);
        end
        #1;
        rst = 1'b1;
        tick();
        @(negedge clk);
        n_checks++;
        if (obs !== EXP_IDLE) begin
            n_errors++;
            $display("FAIL after_fwait_reset: got %b want %b", obs, EXP_IDLE);
        end
        tick();
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_icache_stall();
        test_load_use();
        test_div();
        test_exc_over_div();
        test_fetch_cancel();
        test_dcache_exc();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush sequencer for the seven-register MIPS pipeline: PC, PF_IF, IF_ID, ID_EX, EX_MEM1, MEM1_MEM2 and MEM2_WB. It combines cache-miss, load-use and divider stall requests with exception/eret flush requests. From these it drives every stage register's write-enable and flush. It also owns the multi-cycle divider occupancy counter and the fetch-cancel sequence for exceptions that arrive during an outstanding instruction fetch.

## Interface
Parameters:
- DIV_CYCLES, 32, number of EX stall cycles for a div/divu (≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, **asynchronous, active-low**.
- icache_stall  in  1  instruction in IF waiting on icache.
- icache_busy  in  1  icache has an uncancellable outstanding refill.
- load_use  in  1  ID instruction depends on a load in EX.
- EX_start  in  1  divide instruction present in EX.
- dcache_stall  in  1  instruction in MEM2 waiting on dcache/uncache.
- exc_flush  in  1  exception or eret signalled by MEM1 (level; held while MEM1 is frozen).
- PCWr, PF_IFWr, IF_IDWr, ID_EXWr, EX_MEM1Wr, MEM1_MEM2Wr, MEM2_WBWr  out  1 each  register write-enables.
- PF_Flush, IF_Flush, ID_Flush, EX_Flush, MEM1_Flush, MEM2_Flush  out  1 each  flush PF_IF, IF_ID, ID_EX, EX_MEM1, MEM1_MEM2 and MEM2_WB respectively.
- fetch_cancel  out  1  discard data returned by the icache.
- div_busy  out  1  divider is stalling EX.

## Operation
- Stall rule: a stall at stage k holds registers PC through R_k (Wr=0) and flushes R_{k+1} (a bubble). The oldest stall wins.
  - icache_stall: k = PF_IF.
  - load_use: k = IF_ID.
  - div_busy: k = ID_EX.
  - dcache_stall: k = MEM1_MEM2.
- Priority: dcache_stall > exc_flush > div_busy > load_use > icache_stall.
- exc_flush is accepted only when dcache_stall=0. In the accept cycle:
  - PCWr=1, which loads the vector or EPC.
  - PF_Flush, IF_Flush, ID_Flush, EX_Flush and MEM1_Flush are all 1.
  - MEM2_WBWr=1.
  - The divider counter is cleared.
- State machine, state RUN or FWAIT:
  - RUN→FWAIT when exc_flush is accepted while icache_busy=1.
  - In FWAIT: PCWr=0, PF_IFWr=0, IF_Flush=1, fetch_cancel=1. Older registers still obey dcache_stall.
  - FWAIT→RUN on the first cycle icache_busy=0. That cycle still holds fetch_cancel=1.
  - An exc_flush during FWAIT is ignored, because the pipeline front is already empty.
- Divider counter:
  - div_busy = EX_start & ~div_done.
  - While div_busy: cnt increments. When cnt = DIV_CYCLES-1, set div_done and reset cnt to 0.
  - div_done clears when EX_MEM1Wr=1 and no div_busy.
  - Result: exactly DIV_CYCLES stall cycles per divide.
  - A div_busy masked by dcache_stall still counts.
- No stall and no flush: all Wr=1, all Flush=0.

## Timing
- All Wr/Flush outputs are combinational from the current inputs plus registered state (state, cnt, div_done). There is zero-cycle latency from request to enable.
- Reset (rst=0, asynchronous): state=RUN, cnt=0, div_done=0. With idle inputs the outputs are all Wr=1, all Flush=0, fetch_cancel=0, div_busy=0.
- Reset deasserted mid-divide or in FWAIT: the block returns to RUN with the counter cleared. No pending flush survives reset.
- Simultaneous events:
  - exc_flush with icache_busy=0: RUN is kept; one flush cycle only.
  - exc_flush with load_use or div_busy: flush wins.
  - dcache_stall with exc_flush: the stall wins and the flush is taken on the first non-stalled cycle.
- cnt width is $clog2(DIV_CYCLES). No wrap is possible past DIV_CYCLES-1.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - Adds output perf_stall_cyc (32 bit), counting cycles with any Wr=0.
  - Adds output perf_flush_cnt (32 bit), counting accepted exc_flush events.
  - Both counters wrap modulo 2^32 and reset to 0.
- PIPE_CTRL_PERF_EN undefined: neither port nor counter exists, and behaviour is otherwise identical.

## Structure
- pipe_ctrl_pkg holds:
  - the stage index constants (PC=0 … MEM2_WB=6);
  - the state enum (RUN, FWAIT);
  - the stall-source priority encoding.
- Sub-module div_stall_cnt, parameterised by DIV_CYCLES:
  - inputs EX_start, advance (=EX_MEM1Wr), clear (accepted flush);
  - outputs div_busy.
- The top level does priority resolution, Wr/Flush decode and FWAIT tracking.

## Test plan
- icache_stall=1 alone for 3 cycles → PCWr=PF_IFWr=0, IF_Flush=1, all other Wr=1 each cycle.
- EX_start held with DIV_CYCLES=32 → div_busy=1 and ID_EXWr=0, EX_Flush=1 for exactly 32 cycles, then EX_MEM1Wr=1 and div_busy=0.
- load_use and icache_stall together → IF_IDWr=0 and ID_Flush=1, with IF_Flush=0 (the older stall wins).
- exc_flush with icache_busy=1 for 4 cycles → in the accept cycle, PCWr=1 and five flushes; then 4 FWAIT cycles plus 1 with fetch_cancel=1 and PCWr=0; then RUN.
- dcache_stall and exc_flush for 2 cycles, then dcache_stall=0 → the first 2 cycles show MEM2_Flush=1, MEM1_MEM2Wr=0, no PC redirect; the flush is taken on cycle 3.
- rst pulsed low mid-divide (cnt=10) → immediate reset values; a subsequent EX_start stalls a full 32 cycles.
